// File: rtl/fifo_pkg.sv
// Shared types and defaults for the single-clock parametrised FIFO family.
// Imported by the FIFO RTL, its interface and the monitors built on it.
package fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic {
    PUSH_IDLE = 1'b0,
    PUSH_REQ  = 1'b1
  } push_t;

  typedef enum logic {
    POP_IDLE = 1'b0,
    POP_REQ  = 1'b1
  } pop_t;

  typedef logic [DATA_W_DEF-1:0] valores_t;

  // Snapshot of every FIFO flag, packed so monitors can sample it in one go
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int cntWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_if.sv
// Parametrised FIFO interface with the occupancy and error status signals.
// Modports split the bundle into DUT, producer, consumer and monitor views.
interface fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input logic clk
);

  logic                    rst_n;
  logic                    push;
  logic                    pop;
  logic [DATA_W-1:0]       data_in;
  logic [DATA_W-1:0]       data_out;
  logic                    full;
  logic                    empty;
  logic                    almost_full;
  logic                    almost_empty;
  logic [$clog2(DEPTH):0]  count;
  logic                    overflow;
  logic                    underflow;
  fifo_status_t            status;

  assign status = '{full, empty, almost_full, almost_empty, overflow, underflow};

  modport dut (
    input  clk, rst_n, push, pop, data_in,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport producer (
    input  clk, full, almost_full, overflow, count,
    output push, data_in
  );

  modport consumer (
    input  clk, data_out, empty, almost_empty, underflow, count,
    output pop
  );

  modport monitor (
    input clk, rst_n, push, pop, data_in, data_out, full, empty,
          almost_full, almost_empty, count, overflow, underflow, status
  );

endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; pointers alone define validity.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered or fall-through read, programmable
// almost-full/almost-empty thresholds, occupancy count and error pulses.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       data_in,
  output logic [DATA_W-1:0]       data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_pushOk;
  logic              w_popOk;
  logic [DATA_W-1:0] w_rdData;
  fifo_status_t      w_status;

  // Flags come straight from the count register, so they describe the state
  // left by the last edge and never look ahead at this cycle's requests.
  always_comb begin
    w_status              = '0;
    w_status.full         = (r_count == FULL_CNT);
    w_status.empty        = (r_count == '0);
    w_status.almost_full  = (r_count >= AF_CNT);
    w_status.almost_empty = (r_count <= AE_CNT);
    w_status.overflow     = r_overflow;
    w_status.underflow    = r_underflow;
  end

  // A pop on a full FIFO frees a slot, so a simultaneous push still lands.
  assign w_popOk  = pop & ~w_status.empty;
  assign w_pushOk = push & (~w_status.full | w_popOk);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_popOk) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_pushOk, w_popOk})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overflow  <= push & ~w_pushOk;
      r_underflow <= pop & w_status.empty;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_pushOk),
    .i_waddr (r_wrPtr),
    .i_wdata (data_in),
    .i_raddr (r_rdPtr),
    .o_rdata (w_rdData)
  );

  // Fall-through shows the head directly; registered mode captures it on pop.
  if (FWFT != 0) begin : g_fwft
    assign data_out = w_rdData;
  end else begin : g_regRead
    logic [DATA_W-1:0] r_dataOut;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_dataOut <= '0;
      end else if (w_popOk) begin
        r_dataOut <= w_rdData;
      end
    end

    assign data_out = r_dataOut;
  end

  assign full         = w_status.full;
  assign empty        = w_status.empty;
  assign almost_full  = w_status.almost_full;
  assign almost_empty = w_status.almost_empty;
  assign overflow     = w_status.overflow;
  assign underflow    = w_status.underflow;
  assign count        = r_count;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a registered-read and a fall-through
// instance share one stimulus stream and are checked against expected values.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       push;
  logic       pop;
  logic [7:0] dataIn;

  logic [7:0] dataOut0, dataOut1;
  logic       full0, empty0, almostFull0, almostEmpty0, overflow0, underflow0;
  logic       full1, empty1, almostFull1, almostEmpty1, overflow1, underflow1;
  logic [4:0] count0, count1;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) dutReg (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .data_in(dataIn),
    .data_out(dataOut0), .full(full0), .empty(empty0), .almost_full(almostFull0),
    .almost_empty(almostEmpty0), .count(count0), .overflow(overflow0), .underflow(underflow0)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) dutFwft (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .data_in(dataIn),
    .data_out(dataOut1), .full(full1), .empty(empty1), .almost_full(almostFull1),
    .almost_empty(almostEmpty1), .count(count1), .overflow(overflow1), .underflow(underflow1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; push = 1'b1; pop = 1'b1; dataIn = 8'h77;
    tick();
    tick();
    compared++;
    if ({count0, empty0, full0, almostEmpty0, almostFull0, overflow0, underflow0, dataOut0} !==
        {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      mismatched++;
      $display("[TB] FAIL reset_reg: got cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b dout=%h, want 0 1 0 1 0 0 0 00",
               count0, empty0, full0, almostEmpty0, almostFull0, overflow0, underflow0, dataOut0);
    end
    compared++;
    if ({count1, empty1, full1, almostEmpty1, almostFull1, overflow1, underflow1} !==
        {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL reset_fwft: got cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b, want 0 1 0 1 0 0 0",
               count1, empty1, full1, almostEmpty1, almostFull1, overflow1, underflow1);
    end
    rst_n = 1'b1; push = 1'b0; pop = 1'b0;
    tick();
    compared++;
    if ({count0, empty0, underflow0, overflow0} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL reset_idle: got cnt=%0d e=%b un=%b ov=%b, want 0 1 0 0",
               count0, empty0, underflow0, overflow0);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      push = 1'b1; pop = 1'b0; dataIn = 8'(i);
      tick();
      compared++;
      if ({count0, full0, almostFull0, almostEmpty0, empty0, count1, full1, almostFull1, almostEmpty1} !==
          {5'(i), i == 16, i >= 14, i <= 2, 1'b0, 5'(i), i == 16, i >= 14, i <= 2}) begin
        mismatched++;
        $display("[TB] FAIL fill_flags[%0d]: got cnt=%0d f=%b af=%b ae=%b e=%b | fwft cnt=%0d f=%b af=%b ae=%b",
                 i, count0, full0, almostFull0, almostEmpty0, empty0, count1, full1, almostFull1, almostEmpty1);
      end
    end
    compared++;
    if (dataOut1 !== 8'h01) begin
      mismatched++;
      $display("[TB] FAIL fill_fwft_head: got %h want 01", dataOut1);
    end
    for (int i = 1; i <= 16; i++) begin
      push = 1'b0; pop = 1'b1;
      tick();
      compared++;
      if ({dataOut0, count0, empty0} !== {8'(i), 5'(16 - i), i == 16}) begin
        mismatched++;
        $display("[TB] FAIL drain[%0d]: got dout=%h cnt=%0d e=%b want %h %0d %b",
                 i, dataOut0, count0, empty0, 8'(i), 16 - i, i == 16);
      end
      if (i < 16) begin
        compared++;
        if (dataOut1 !== 8'(i + 1)) begin
          mismatched++;
          $display("[TB] FAIL drain_fwft[%0d]: got %h want %h", i, dataOut1, 8'(i + 1));
        end
      end
    end
    pop = 1'b0;
  endtask

  task automatic test_overflow();
    for (int j = 0; j < 16; j++) begin
      push = 1'b1; pop = 1'b0; dataIn = 8'(8'h20 + j);
      tick();
    end
    dataIn = 8'hAA;
    tick();
    compared++;
    if ({overflow0, overflow1, count0, full0} !== {1'b1, 1'b1, 5'd16, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL overflow_pulse: got ov=%b/%b cnt=%0d f=%b want 1/1 16 1",
               overflow0, overflow1, count0, full0);
    end
    push = 1'b0;
    tick();
    compared++;
    if ({overflow0, count0} !== {1'b0, 5'd16}) begin
      mismatched++;
      $display("[TB] FAIL overflow_clear: got ov=%b cnt=%0d want 0 16", overflow0, count0);
    end
    push = 1'b1; pop = 1'b1; dataIn = 8'hBB;
    tick();
    compared++;
    if ({count0, full0, overflow0, dataOut0, dataOut1} !== {5'd16, 1'b1, 1'b0, 8'h20, 8'h21}) begin
      mismatched++;
      $display("[TB] FAIL full_push_pop: got cnt=%0d f=%b ov=%b dout=%h fwft=%h want 16 1 0 20 21",
               count0, full0, overflow0, dataOut0, dataOut1);
    end
    push = 1'b0; pop = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      tick();
      compared++;
      if ({dataOut0, count0} !== {(j < 16) ? 8'(8'h20 + j) : 8'hBB, 5'(16 - j)}) begin
        mismatched++;
        $display("[TB] FAIL ovf_drain[%0d]: got dout=%h cnt=%0d want %h %0d",
                 j, dataOut0, count0, (j < 16) ? 8'(8'h20 + j) : 8'hBB, 16 - j);
      end
      if (j < 16) begin
        compared++;
        if (dataOut1 !== ((j < 15) ? 8'(8'h21 + j) : 8'hBB)) begin
          mismatched++;
          $display("[TB] FAIL ovf_drain_fwft[%0d]: got %h want %h",
                   j, dataOut1, (j < 15) ? 8'(8'h21 + j) : 8'hBB);
        end
      end
    end
    pop = 1'b0;
  endtask

  task automatic test_underflow();
    pop = 1'b1;
    for (int j = 0; j < 2; j++) begin
      tick();
      compared++;
      if ({underflow0, underflow1, count0, empty0, dataOut0} !== {1'b1, 1'b1, 5'd0, 1'b1, 8'hBB}) begin
        mismatched++;
        $display("[TB] FAIL underflow_pulse[%0d]: got un=%b/%b cnt=%0d e=%b dout=%h want 1/1 0 1 bb",
                 j, underflow0, underflow1, count0, empty0, dataOut0);
      end
    end
    pop = 1'b0;
    tick();
    compared++;
    if (underflow0 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL underflow_clear: got %b want 0", underflow0);
    end
    push = 1'b1; pop = 1'b1; dataIn = 8'h55;
    tick();
    compared++;
    if ({underflow0, count0, empty0, overflow0, dataOut0, dataOut1} !== {1'b1, 5'd1, 1'b0, 1'b0, 8'hBB, 8'h55}) begin
      mismatched++;
      $display("[TB] FAIL empty_push_pop: got un=%b cnt=%0d e=%b ov=%b dout=%h fwft=%h want 1 1 0 0 bb 55",
               underflow0, count0, empty0, overflow0, dataOut0, dataOut1);
    end
    push = 1'b0; pop = 1'b1;
    tick();
    compared++;
    if ({dataOut0, count0, underflow0} !== {8'h55, 5'd0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL empty_push_pop_read: got dout=%h cnt=%0d un=%b want 55 0 0",
               dataOut0, count0, underflow0);
    end
    pop = 1'b0;
  endtask

  task automatic test_fwft();
    push = 1'b1; pop = 1'b0; dataIn = 8'h3C;
    tick();
    compared++;
    if ({empty1, count1, dataOut1} !== {1'b0, 5'd1, 8'h3C}) begin
      mismatched++;
      $display("[TB] FAIL fwft_first_word: got e=%b cnt=%0d dout=%h want 0 1 3c", empty1, count1, dataOut1);
    end
    dataIn = 8'h4D;
    tick();
    compared++;
    if ({count1, dataOut1} !== {5'd2, 8'h3C}) begin
      mismatched++;
      $display("[TB] FAIL fwft_hold_head: got cnt=%0d dout=%h want 2 3c", count1, dataOut1);
    end
    push = 1'b0; pop = 1'b1;
    tick();
    compared++;
    if ({count1, dataOut1, dataOut0} !== {5'd1, 8'h4D, 8'h3C}) begin
      mismatched++;
      $display("[TB] FAIL fwft_next_word: got cnt=%0d fwft=%h reg=%h want 1 4d 3c", count1, dataOut1, dataOut0);
    end
    tick();
    compared++;
    if ({count0, empty0, dataOut0} !== {5'd0, 1'b1, 8'h4D}) begin
      mismatched++;
      $display("[TB] FAIL fwft_last_pop: got cnt=%0d e=%b reg=%h want 0 1 4d", count0, empty0, dataOut0);
    end
    pop = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 3; j++) begin
      push = 1'b1; pop = 1'b0; dataIn = 8'(8'h61 + j);
      tick();
    end
    for (int j = 0; j < 6; j++) begin
      push = 1'b1; pop = 1'b1; dataIn = 8'(8'h64 + j);
      tick();
      compared++;
      if ({count0, dataOut0, dataOut1} !== {5'd3, 8'(8'h61 + j), 8'(8'h62 + j)}) begin
        mismatched++;
        $display("[TB] FAIL back_to_back[%0d]: got cnt=%0d dout=%h fwft=%h want 3 %h %h",
                 j, count0, dataOut0, dataOut1, 8'(8'h61 + j), 8'(8'h62 + j));
      end
    end
    push = 1'b0; pop = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      compared++;
      if ({dataOut0, count0} !== {8'(8'h67 + j), 5'(2 - j)}) begin
        mismatched++;
        $display("[TB] FAIL b2b_drain[%0d]: got dout=%h cnt=%0d want %h %0d",
                 j, dataOut0, count0, 8'(8'h67 + j), 2 - j);
      end
    end
    pop = 1'b0;
  endtask

  task automatic test_wrap_random();
    logic [7:0] q[$];
    logic [7:0] expD0;
    logic       popOk, pushOk, expOvf, expUnf;

    rst_n = 1'b0; push = 1'b0; pop = 1'b0;
    tick();
    rst_n = 1'b1;
    expD0 = 8'h00;
    for (int k = 0; k < 48; k++) begin
      if (k == 30) begin
        rst_n = 1'b0; push = 1'b1; pop = 1'b1; dataIn = 8'hE7;
        tick();
        compared++;
        if ({count0, empty0, full0, almostEmpty0, almostFull0, overflow0, underflow0, dataOut0} !==
            {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
          mismatched++;
          $display("[TB] FAIL mid_reset: got cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b dout=%h, want 0 1 0 1 0 0 0 00",
                   count0, empty0, full0, almostEmpty0, almostFull0, overflow0, underflow0, dataOut0);
        end
        rst_n = 1'b1; pop = 1'b0; dataIn = 8'h11;
        tick();
        dataIn = 8'h22;
        tick();
        compared++;
        if ({count0, dataOut1} !== {5'd2, 8'h11}) begin
          mismatched++;
          $display("[TB] FAIL fresh_fill: got cnt=%0d fwft=%h want 2 11", count0, dataOut1);
        end
        push = 1'b0; pop = 1'b1;
        tick();
        compared++;
        if (dataOut0 !== 8'h11) begin
          mismatched++;
          $display("[TB] FAIL fresh_read0: got %h want 11", dataOut0);
        end
        tick();
        compared++;
        if ({dataOut0, empty0} !== {8'h22, 1'b1}) begin
          mismatched++;
          $display("[TB] FAIL fresh_read1: got dout=%h e=%b want 22 1", dataOut0, empty0);
        end
        q.delete();
        expD0 = 8'h22;
      end
      push   = (k < 30) ? 1'b1 : ($urandom_range(0, 2) == 0);
      pop    = (k < 30) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      dataIn = 8'($urandom);
      popOk  = pop && (q.size() != 0);
      pushOk = push && ((q.size() < 16) || popOk);
      expOvf = push && !pushOk;
      expUnf = pop && (q.size() == 0);
      if (popOk) expD0 = q.pop_front();
      if (pushOk) q.push_back(dataIn);
      tick();
      compared++;
      if ({count0, full0, empty0, overflow0, underflow0, dataOut0, count1} !==
          {5'(q.size()), q.size() == 16, q.size() == 0, expOvf, expUnf, expD0, 5'(q.size())}) begin
        mismatched++;
        $display("[TB] FAIL stream[%0d]: got cnt=%0d f=%b e=%b ov=%b un=%b dout=%h fcnt=%0d want %0d %b %b %b %b %h",
                 k, count0, full0, empty0, overflow0, underflow0, dataOut0, count1,
                 q.size(), q.size() == 16, q.size() == 0, expOvf, expUnf, expD0);
      end
      if (q.size() != 0) begin
        compared++;
        if (dataOut1 !== q[0]) begin
          mismatched++;
          $display("[TB] FAIL stream_fwft[%0d]: got %h want %h", k, dataOut1, q[0]);
        end
      end
    end
    push = 1'b0; pop = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; dataIn = 8'h00;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_fwft();
    test_back_to_back();
    test_wrap_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
